multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle controller for the 5-bit-opcode CPU datapath.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the datapath strobes: PC select, memory, ALU-source, register-write and ALU control.
- Stalls on a data-memory ready handshake, traps illegal opcodes, counts retired instructions.

Parameters:
- CNT_W, 16: width of the retired-instruction counter.
- TIMEOUT_CYCLES, 16: maximum MEM wait cycles before a trap (used only with the optional feature).
- TRAP_ON_ILLEGAL, 1: 1 = an illegal opcode traps; 0 = it executes as NOP.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  5  opcode from the instruction register; valid from DECODE onward.
- alu_zero  in  1  ALU zero flag, sampled in EXEC for BEQ.
- mem_ready  in  1  data memory has completed the current access.
- ir_write  out  1  latch the instruction register.
- pc_write  out  1  load the PC from the pc_sel source.
- PC  out  3  PC source: 000 PC+1, 001 branch target, 010 jump target, 100 trap vector.
- mem_read  out  1  data memory read strobe.
- mem_write  out  1  data memory write strobe.
- mem_reg  out  1  write-back source: 1 = memory, 0 = ALU.
- alu_src  out  1  ALU operand B: 1 = immediate, 0 = register.
- reg_write  out  1  register file write enable.
- alu_ctrl  out  4  0010 ADD, 0110 SUB, 0000 AND, 0001 OR.
- illegal  out  1  one-cycle pulse on trap entry.
- halted  out  1  high while in HALT.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Opcodes:
  - 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR: R-type.
  - 5 ADDI, 6 LW, 7 SW: immediate operand.
  - 8 BEQ, 9 J, 31 HALT.
  - All other values are illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP.
  - State and op_q are registered.
  - All outputs are decoded combinationally from state_q and op_q.
  - op is latched into op_q in DECODE.
- Reset:
  - After a clock edge with rst=1: state=IDLE, op_q=0, retired=0.
  - In IDLE every output is 0.
  - IDLE goes to FETCH on the next cycle.
  - rst has priority in every state, including a pending MEM wait; an aborted access asserts no further strobes.
- FETCH: ir_write=1, pc_write=1, PC=000; next state DECODE.
- DECODE:
  - NOP: retire, go to FETCH.
  - J: pc_write=1, PC=010, retire, go to FETCH.
  - HALT: go to HALT.
  - Illegal: go to TRAP, or act as NOP when TRAP_ON_ILLEGAL=0.
  - All others: go to EXEC.
- EXEC:
  - alu_ctrl is per opcode; ADDI/LW/SW use ADD, BEQ uses SUB.
  - alu_src=1 for ADDI, LW, SW.
  - BEQ: pc_write=alu_zero, PC=001, retire, go to FETCH.
  - LW, SW: go to MEM.
  - All others: go to WB.
- MEM:
  - mem_read (LW) or mem_write (SW) is held, with alu_ctrl/alu_src held, until mem_ready=1 is sampled.
  - On mem_ready: LW goes to WB; SW retires and goes to FETCH.
- WB: reg_write=1; mem_reg=1 only for LW; alu_ctrl/alu_src held; retire; go to FETCH.
- HALT: halted=1, all strobes 0; exited only by rst.
- TRAP: illegal=1, pc_write=1, PC=100; one cycle, then FETCH; not counted as retired.
- Latency (no memory waits): J/NOP 2 cycles, BEQ 3, R-type/ADDI/SW 4, LW 5. Each mem_ready=0 cycle adds 1.
- Retire: retired increments on the last cycle of each instruction and wraps modulo 2^CNT_W.
- Exclusivity: mem_read and mem_write are never high together; reg_write is never high outside WB.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on MEM entry and increments each cycle mem_ready=0.
  - On reaching TIMEOUT_CYCLES with mem_ready=0: go to TRAP (illegal pulses), instruction not retired.
  - mem_ready=1 on the same cycle wins over the timeout.
- Undefined: MEM waits indefinitely; no counter logic is synthesized.

Decomposition:
- Package cpu_ctrl_pkg:
  - opcode localparams;
  - ALU_ADD/SUB/AND/OR codes;
  - PC_INC/BR/JMP/TRAP codes;
  - state encoding.
- Sub-module ctrl_decode: combinational op_q -> {class, alu_ctrl, alu_src, mem_reg, is_illegal}; instantiated once.
- The sequencer FSM, wait counter and retired counter stay in the top module.

Test Plan:
- rst=1 for 2 cycles, then op=1 (ADD) -> all outputs 0 in IDLE; FETCH, DECODE, EXEC (alu_ctrl=0010), WB (reg_write=1, mem_reg=0); retired=1.
- op=6 (LW), mem_ready low 3 cycles -> mem_read held 4 MEM cycles; WB with mem_reg=1; 8 cycles total; no mem_write.
- op=8 (BEQ) with alu_zero=1, then alu_zero=0 -> EXEC pc_write=1/PC=001 then pc_write=0; alu_ctrl=0110; retired +2.
- op=9 (J), then op=12 (illegal) -> J: pc_write in DECODE with PC=010. Illegal: TRAP with illegal=1, PC=100; retired +1 only.
- op=31 (HALT) -> halted=1 for 20 cycles, no strobes; assert rst mid-HALT -> IDLE then FETCH.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, op=7 (SW), mem_ready=0 -> TRAP after 4 wait cycles; retired unchanged. Repeat with mem_ready=1 on cycle 4 -> normal retire.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU controller: opcodes, ALU control
// codes, PC-source codes, sequencer states and the decoded-instruction payload.
package cpu_ctrl_pkg;

    localparam int unsigned OP_W   = 5;
    localparam int unsigned ALU_W  = 4;
    localparam int unsigned PCS_W  = 3;

    // Opcodes
    localparam logic [OP_W-1:0] OP_NOP  = 5'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 5'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd2;
    localparam logic [OP_W-1:0] OP_AND  = 5'd3;
    localparam logic [OP_W-1:0] OP_OR   = 5'd4;
    localparam logic [OP_W-1:0] OP_ADDI = 5'd5;
    localparam logic [OP_W-1:0] OP_LW   = 5'd6;
    localparam logic [OP_W-1:0] OP_SW   = 5'd7;
    localparam logic [OP_W-1:0] OP_BEQ  = 5'd8;
    localparam logic [OP_W-1:0] OP_J    = 5'd9;
    localparam logic [OP_W-1:0] OP_HALT = 5'd31;

    // ALU control codes
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;

    // PC source select
    localparam logic [PCS_W-1:0] PC_INC  = 3'b000;
    localparam logic [PCS_W-1:0] PC_BR   = 3'b001;
    localparam logic [PCS_W-1:0] PC_JMP  = 3'b010;
    localparam logic [PCS_W-1:0] PC_TRAP = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_TRAP
    } state_t;

    // Instruction class: selects the path taken after DECODE
    typedef enum logic [2:0] {
        CL_NOP,
        CL_ALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JUMP,
        CL_HALT
    } op_class_t;

    typedef struct packed {
        op_class_t        cls;
        logic [ALU_W-1:0] alu_ctrl;
        logic             alu_src;
        logic             mem_reg;
        logic             is_illegal;
    } dec_t;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Controller <-> datapath/memory signal bundle.
//   op, alu_zero, mem_ready          : datapath/memory -> controller
//   ir_write, pc_write, PC, mem_read,
//   mem_write, mem_reg, alu_src,
//   reg_write, alu_ctrl              : controller strobes -> datapath
//   illegal, halted, retired         : controller status
// master = controller side, slave = datapath side.
interface multicycle_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       op;
    logic             alu_zero;
    logic             mem_ready;
    logic             ir_write;
    logic             pc_write;
    logic [2:0]       PC;
    logic             mem_read;
    logic             mem_write;
    logic             mem_reg;
    logic             alu_src;
    logic             reg_write;
    logic [3:0]       alu_ctrl;
    logic             illegal;
    logic             halted;
    logic [CNT_W-1:0] retired;

    modport master (
        input  op, alu_zero, mem_ready,
        output ir_write, pc_write, PC, mem_read, mem_write, mem_reg,
               alu_src, reg_write, alu_ctrl, illegal, halted, retired
    );

    modport slave (
        output op, alu_zero, mem_ready,
        input  ir_write, pc_write, PC, mem_read, mem_write, mem_reg,
               alu_src, reg_write, alu_ctrl, illegal, halted, retired
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder.
//   op_i  : 5-bit opcode
//   dec_o : instruction class, ALU control, ALU-B source, write-back source,
//           illegal flag
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    output dec_t            dec_o
);

    always_comb begin
        dec_o.cls        = CL_NOP;
        dec_o.alu_ctrl   = ALU_AND;
        dec_o.alu_src    = 1'b0;
        dec_o.mem_reg    = 1'b0;
        dec_o.is_illegal = 1'b0;
        case (op_i)
            OP_NOP:  dec_o.cls = CL_NOP;
            OP_ADD:  begin dec_o.cls = CL_ALU; dec_o.alu_ctrl = ALU_ADD; end
            OP_SUB:  begin dec_o.cls = CL_ALU; dec_o.alu_ctrl = ALU_SUB; end
            OP_AND:  begin dec_o.cls = CL_ALU; dec_o.alu_ctrl = ALU_AND; end
            OP_OR:   begin dec_o.cls = CL_ALU; dec_o.alu_ctrl = ALU_OR;  end
            OP_ADDI: begin
                dec_o.cls      = CL_ALU;
                dec_o.alu_ctrl = ALU_ADD;
                dec_o.alu_src  = 1'b1;
            end
            OP_LW: begin
                dec_o.cls      = CL_LOAD;
                dec_o.alu_ctrl = ALU_ADD;
                dec_o.alu_src  = 1'b1;
                dec_o.mem_reg  = 1'b1;
            end
            OP_SW: begin
                dec_o.cls      = CL_STORE;
                dec_o.alu_ctrl = ALU_ADD;
                dec_o.alu_src  = 1'b1;
            end
            OP_BEQ:  begin dec_o.cls = CL_BRANCH; dec_o.alu_ctrl = ALU_SUB; end
            OP_J:    dec_o.cls = CL_JUMP;
            OP_HALT: dec_o.cls = CL_HALT;
            // Illegal opcodes decode as NOP with the flag set
            default: dec_o.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle controller for the 5-bit-opcode CPU datapath.
// Steps instructions through FETCH/DECODE/EXEC/MEM/WB, drives datapath
// strobes, stalls on mem_ready, traps illegal opcodes and counts retirements.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : multicycle_sequencer_if.master (op/alu_zero/mem_ready in;
//          strobes, illegal, halted, retired out)
// Parameters: CNT_W (retired counter width), TIMEOUT_CYCLES (MEM wait limit),
//             TRAP_ON_ILLEGAL (1 = trap, 0 = illegal executes as NOP).
// Optional: define MEM_TIMEOUT_EN to trap when MEM waits TIMEOUT_CYCLES.
// Strobes are decoded combinationally from the state and latched opcode.
module multicycle_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 16,
    parameter int unsigned TRAP_ON_ILLEGAL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_sequencer_if.master bus
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [CNT_W-1:0]  retired_q;
    logic              retire_c;

    logic [OP_W-1:0]   dec_op;
    dec_t              dec;

    logic              ir_write_c;
    logic              pc_write_c;
    logic [PCS_W-1:0]  pc_sel_c;
    logic              mem_read_c;
    logic              mem_write_c;
    logic              mem_reg_c;
    logic              alu_src_c;
    logic              reg_write_c;
    logic [ALU_W-1:0]  alu_ctrl_c;
    logic              illegal_c;
    logic              halted_c;

    // op_q is only loaded at the end of DECODE, so DECODE looks at the live opcode
    assign dec_op = (state_q == S_DECODE) ? bus.op : op_q;

    ctrl_decode u_decode (
        .op_i  (dec_op),
        .dec_o (dec)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_q;

    // Held at zero outside MEM, so it is clear on every MEM entry
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= '0;
        end else if (state_q != S_MEM) begin
            wait_q <= '0;
        end else if (!bus.mem_ready) begin
            wait_q <= wait_q + WAIT_W'(1);
        end
    end
`endif

    // State, latched opcode and retired counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            if (retire_c) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Next state and strobe decode
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        retire_c    = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        pc_sel_c    = PC_INC;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        mem_reg_c   = 1'b0;
        alu_src_c   = 1'b0;
        reg_write_c = 1'b0;
        alu_ctrl_c  = '0;
        illegal_c   = 1'b0;
        halted_c    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                ir_write_c = 1'b1;
                pc_write_c = 1'b1;
                pc_sel_c   = PC_INC;
                state_d    = S_DECODE;
            end

            S_DECODE: begin
                op_d = bus.op;
                case (dec.cls)
                    CL_NOP: begin
                        if (dec.is_illegal && (TRAP_ON_ILLEGAL != 0)) begin
                            state_d = S_TRAP;
                        end else begin
                            retire_c = 1'b1;
                            state_d  = S_FETCH;
                        end
                    end
                    CL_JUMP: begin
                        pc_write_c = 1'b1;
                        pc_sel_c   = PC_JMP;
                        retire_c   = 1'b1;
                        state_d    = S_FETCH;
                    end
                    CL_HALT: state_d = S_HALT;
                    default: state_d = S_EXEC;
                endcase
            end

            S_EXEC: begin
                alu_ctrl_c = dec.alu_ctrl;
                alu_src_c  = dec.alu_src;
                case (dec.cls)
                    CL_BRANCH: begin
                        pc_write_c = bus.alu_zero;
                        pc_sel_c   = PC_BR;
                        retire_c   = 1'b1;
                        state_d    = S_FETCH;
                    end
                    CL_LOAD, CL_STORE: state_d = S_MEM;
                    default:           state_d = S_WB;
                endcase
            end

            S_MEM: begin
                alu_ctrl_c  = dec.alu_ctrl;
                alu_src_c   = dec.alu_src;
                mem_read_c  = (dec.cls == CL_LOAD);
                mem_write_c = (dec.cls == CL_STORE);
                if (bus.mem_ready) begin
                    if (dec.cls == CL_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                // A same-cycle mem_ready takes the branch above instead
                else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_TRAP;
                end
`endif
            end

            S_WB: begin
                reg_write_c = 1'b1;
                mem_reg_c   = dec.mem_reg;
                alu_ctrl_c  = dec.alu_ctrl;
                alu_src_c   = dec.alu_src;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end

            S_HALT: halted_c = 1'b1;

            S_TRAP: begin
                illegal_c  = 1'b1;
                pc_write_c = 1'b1;
                pc_sel_c   = PC_TRAP;
                state_d    = S_FETCH;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.ir_write  = ir_write_c;
    assign bus.pc_write  = pc_write_c;
    assign bus.PC        = pc_sel_c;
    assign bus.mem_read  = mem_read_c;
    assign bus.mem_write = mem_write_c;
    assign bus.mem_reg   = mem_reg_c;
    assign bus.alu_src   = alu_src_c;
    assign bus.reg_write = reg_write_c;
    assign bus.alu_ctrl  = alu_ctrl_c;
    assign bus.illegal   = illegal_c;
    assign bus.halted    = halted_c;
    assign bus.retired   = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: each instruction pushes its
// per-cycle stimulus and expected strobes/retired count; the run loop drives
// one stimulus entry per cycle and compares against the matching expectation.
module tb_multicycle_sequencer;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [2:0] pc;
        logic       mem_read;
        logic       mem_write;
        logic       mem_reg;
        logic       alu_src;
        logic       reg_write;
        logic [3:0] alu_ctrl;
        logic       illegal;
        logic       halted;
    } outs_t;

    typedef struct packed {
        logic       rst;
        logic [4:0] op;
        logic       alu_zero;
        logic       mem_ready;
    } stim_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    multicycle_sequencer_if #(.CNT_W(16)) bus ();

    multicycle_sequencer #(
        .CNT_W           (16),
        .TIMEOUT_CYCLES  (4),
        .TRAP_ON_ILLEGAL (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    stim_t       stim_q[$];
    outs_t       exp_q[$];
    logic [15:0] ret_q[$];
    logic [15:0] exp_ret;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] rnd5();
        return 5'($urandom);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [3:0] alu_of(input logic [4:0] o);
        case (o)
            5'd1, 5'd5, 5'd6, 5'd7: return 4'b0010;
            5'd2, 5'd8:             return 4'b0110;
            5'd4:                   return 4'b0001;
            default:                return 4'b0000;
        endcase
    endfunction

    function automatic logic src_of(input logic [4:0] o);
        return (o == 5'd5) || (o == 5'd6) || (o == 5'd7);
    endfunction

    function automatic outs_t o_fetch();
        outs_t e = '0;
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
        e.pc       = 3'b000;
        return e;
    endfunction

    function automatic outs_t o_decode(input logic [4:0] o);
        outs_t e = '0;
        if (o == 5'd9) begin
            e.pc_write = 1'b1;
            e.pc       = 3'b010;
        end
        return e;
    endfunction

    function automatic outs_t o_exec(input logic [4:0] o, input logic az);
        outs_t e = '0;
        e.alu_ctrl = alu_of(o);
        e.alu_src  = src_of(o);
        if (o == 5'd8) begin
            e.pc_write = az;
            e.pc       = 3'b001;
        end
        return e;
    endfunction

    function automatic outs_t o_mem(input logic [4:0] o);
        outs_t e = '0;
        e.mem_read  = (o == 5'd6);
        e.mem_write = (o == 5'd7);
        e.alu_ctrl  = 4'b0010;
        e.alu_src   = 1'b1;
        return e;
    endfunction

    function automatic outs_t o_wb(input logic [4:0] o);
        outs_t e = '0;
        e.reg_write = 1'b1;
        e.mem_reg   = (o == 5'd6);
        e.alu_ctrl  = alu_of(o);
        e.alu_src   = src_of(o);
        return e;
    endfunction

    function automatic outs_t o_trap();
        outs_t e = '0;
        e.illegal  = 1'b1;
        e.pc_write = 1'b1;
        e.pc       = 3'b100;
        return e;
    endfunction

    function automatic outs_t o_halt();
        outs_t e = '0;
        e.halted = 1'b1;
        return e;
    endfunction

    task automatic push(input logic r, input logic [4:0] o, input logic az,
                        input logic mr, input outs_t e);
        stim_t s;
        s.rst       = r;
        s.op        = o;
        s.alu_zero  = az;
        s.mem_ready = mr;
        stim_q.push_back(s);
        exp_q.push_back(e);
        ret_q.push_back(exp_ret);
    endtask

    // op is only meaningful in DECODE; every other cycle gets a random opcode
    task automatic instr(input logic [4:0] o, input logic az, input int waits,
                         input bit ready_last);
        push(1'b0, rnd5(), rb(), rb(), o_fetch());
        push(1'b0, o, rb(), rb(), o_decode(o));
        case (o)
            5'd0, 5'd9: exp_ret = exp_ret + 16'd1;
            5'd31: ;
            5'd1, 5'd2, 5'd3, 5'd4, 5'd5: begin
                push(1'b0, rnd5(), rb(), rb(), o_exec(o, 1'b0));
                push(1'b0, rnd5(), rb(), rb(), o_wb(o));
                exp_ret = exp_ret + 16'd1;
            end
            5'd6, 5'd7: begin
                push(1'b0, rnd5(), rb(), 1'b0, o_exec(o, 1'b0));
                for (int i = 0; i < waits; i++) push(1'b0, rnd5(), rb(), 1'b0, o_mem(o));
                if (ready_last) begin
                    push(1'b0, rnd5(), rb(), 1'b1, o_mem(o));
                    if (o == 5'd6) push(1'b0, rnd5(), rb(), rb(), o_wb(o));
                    exp_ret = exp_ret + 16'd1;
                end else begin
                    push(1'b0, rnd5(), rb(), rb(), o_trap());
                end
            end
            5'd8: begin
                push(1'b0, rnd5(), az, rb(), o_exec(o, az));
                exp_ret = exp_ret + 16'd1;
            end
            default: push(1'b0, rnd5(), rb(), rb(), o_trap());
        endcase
    endtask

    task automatic run();
        stim_t       s;
        outs_t       e;
        outs_t       g;
        logic [15:0] r;
        while (stim_q.size() > 0) begin
            @(posedge clk);
            #1;
            s = stim_q.pop_front();
            rst           = s.rst;
            bus.op        = s.op;
            bus.alu_zero  = s.alu_zero;
            bus.mem_ready = s.mem_ready;
            @(negedge clk);
            e = exp_q.pop_front();
            r = ret_q.pop_front();
            g.ir_write  = bus.ir_write;
            g.pc_write  = bus.pc_write;
            g.pc        = bus.PC;
            g.mem_read  = bus.mem_read;
            g.mem_write = bus.mem_write;
            g.mem_reg   = bus.mem_reg;
            g.alu_src   = bus.alu_src;
            g.reg_write = bus.reg_write;
            g.alu_ctrl  = bus.alu_ctrl;
            g.illegal   = bus.illegal;
            g.halted    = bus.halted;
            check($sformatf("cyc%0d strobes", cyc), 32'(g), 32'(e));
            check($sformatf("cyc%0d retired", cyc), 32'(bus.retired), 32'(r));
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.op        = 5'd1;
        bus.alu_zero  = 1'b0;
        bus.mem_ready = 1'b0;
        exp_ret       = 16'd0;
        repeat (2) @(posedge clk);

        push(1'b0, 5'd1, 1'b0, 1'b0, '0);       // IDLE after reset
        instr(5'd1, 1'b0, 0, 1'b1);             // ADD
        instr(5'd6, 1'b0, 3, 1'b1);             // LW, 3 wait cycles
        instr(5'd8, 1'b1, 0, 1'b1);             // BEQ taken
        instr(5'd8, 1'b0, 0, 1'b1);             // BEQ not taken
        instr(5'd9, 1'b0, 0, 1'b1);             // J
        instr(5'd12, 1'b0, 0, 1'b1);            // illegal
        instr(5'd2, 1'b0, 0, 1'b1);             // SUB
        instr(5'd3, 1'b0, 0, 1'b1);             // AND
        instr(5'd4, 1'b0, 0, 1'b1);             // OR
        instr(5'd5, 1'b0, 0, 1'b1);             // ADDI
        instr(5'd0, 1'b0, 0, 1'b1);             // NOP
        instr(5'd7, 1'b0, 2, 1'b1);             // SW, 2 wait cycles
        instr(5'd20, 1'b0, 0, 1'b1);            // illegal

        // Reset during a pending LW wait: next cycle is IDLE with no strobes
        push(1'b0, rnd5(), 1'b0, 1'b0, o_fetch());
        push(1'b0, 5'd6, 1'b0, 1'b0, o_decode(5'd6));
        push(1'b0, rnd5(), 1'b0, 1'b0, o_exec(5'd6, 1'b0));
        push(1'b0, rnd5(), 1'b0, 1'b0, o_mem(5'd6));
        push(1'b1, rnd5(), 1'b0, 1'b0, o_mem(5'd6));
        exp_ret = 16'd0;
        push(1'b0, rnd5(), 1'b0, 1'b1, '0);
        instr(5'd1, 1'b0, 0, 1'b1);

`ifdef MEM_TIMEOUT_EN
        instr(5'd7, 1'b0, 4, 1'b0);             // SW times out -> TRAP
        instr(5'd7, 1'b0, 3, 1'b1);             // ready on 4th wait cycle wins
`endif

        // HALT holds until reset, then IDLE and a fresh fetch
        instr(5'd31, 1'b0, 0, 1'b1);
        for (int i = 0; i < 20; i++) push(1'b0, rnd5(), rb(), rb(), o_halt());
        push(1'b1, rnd5(), 1'b0, 1'b0, o_halt());
        exp_ret = 16'd0;
        push(1'b0, rnd5(), 1'b0, 1'b0, '0);
        instr(5'd6, 1'b0, 0, 1'b1);

        run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
